seq_player: RTL and testbench

//  Reader side of the game's pattern register file. After the game FSM loads the

---
 rtl/seq_player_if.sv | 28 ++
 rtl/seq_player.sv | 131 +++++++++++++
 tb/tb_seq_player.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/seq_player_if.sv
// Playback bus between the game controller and seq_player: start/abort control,
// pattern length, register-file read port and display/status outputs.
interface seq_player_if #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 3
);
  localparam int unsigned LenW  = $clog2(DEPTH + 1);
  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              start_i;
  logic              abort_i;
  logic [LenW-1:0]   len_i;
  logic [AddrW-1:0]  rd_addr_o;
  logic [DATA_W-1:0] rd_data_i;
  logic [7:0]        seg_o;
  logic              busy_o;
  logic              done_o;

  modport master (
    output start_i, abort_i, len_i, rd_data_i,
    input  rd_addr_o, seg_o, busy_o, done_o
  );

  modport slave (
    input  start_i, abort_i, len_i, rd_data_i,
    output rd_addr_o, seg_o, busy_o, done_o
  );
endinterface

// File: rtl/seq_player.sv
// Reads the stored digit pattern back from the register file and plays it on the
// seven-segment display: each digit lit for ON_CYCLES, then blanked for OFF_CYCLES.
module seq_player #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_W     = 3,
  parameter int unsigned ON_CYCLES  = 4,
  parameter int unsigned OFF_CYCLES = 2
) (
  input logic         clk,
  input logic         rst,
  seq_player_if.slave bus
);
  localparam int unsigned LenW      = $clog2(DEPTH + 1);
  localparam int unsigned AddrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TimerMaxV = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned TimerW    = $clog2(TimerMaxV + 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StShow,
    StGap,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [AddrW-1:0]  idx_q, idx_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [DATA_W-1:0] digit_q, digit_d;
  logic [LenW-1:0]   len_q, len_d;

  logic [TimerW-1:0] timer_inc;
  logic [LenW-1:0]   len_clamp;
  logic              last_entry;

  function automatic logic [6:0] enc7(input logic [DATA_W-1:0] d);
    logic [6:0] s;
    case (int'(d))
      0:       s = 7'h3F;
      1:       s = 7'h06;
      2:       s = 7'h5B;
      3:       s = 7'h4F;
      4:       s = 7'h66;
      5:       s = 7'h6D;
      6:       s = 7'h7D;
      7:       s = 7'h07;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Saturating increment so the timer can never wrap back to zero.
  assign timer_inc  = (timer_q == TimerW'(TimerMaxV)) ? timer_q : timer_q + TimerW'(1);
  assign len_clamp  = (bus.len_i > LenW'(DEPTH)) ? LenW'(DEPTH) : bus.len_i;
  assign last_entry = (LenW'(idx_q) == (len_q - LenW'(1)));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    digit_d = digit_q;
    len_d   = len_q;

    case (state_q)
      StIdle: begin
        if (bus.start_i && !bus.abort_i) begin
          len_d   = len_clamp;
          idx_d   = '0;
          state_d = (len_clamp == '0) ? StDone : StFetch;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        digit_d = bus.rd_data_i;
        timer_d = '0;
        state_d = StShow;
      end
      StShow: begin
        if (timer_q == TimerW'(ON_CYCLES - 1)) begin
          timer_d = '0;
          state_d = StGap;
        end else begin
          timer_d = timer_inc;
        end
      end
      StGap: begin
        if (timer_q == TimerW'(OFF_CYCLES - 1)) begin
          timer_d = '0;
          if (last_entry) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + AddrW'(1);
            state_d = StFetch;
          end
        end else begin
          timer_d = timer_inc;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && bus.abort_i) begin
      state_d = StIdle;
      timer_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      timer_q <= '0;
      digit_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      digit_q <= digit_d;
      len_q   <= len_d;
    end
  end

  // Outputs depend on registered state only.
  assign bus.rd_addr_o = idx_q;
  assign bus.busy_o    = (state_q != StIdle);
  assign bus.done_o    = (state_q == StDone);
  assign bus.seg_o     = (state_q == StShow) ? {last_entry, enc7(digit_q)} : 8'h00;
endmodule

// File: tb/tb_seq_player.sv
// Self-checking bench for seq_player: expected display traces are built per cycle
// from the playback rules and compared against the DUT at each falling edge.
module tb_seq_player;
  localparam int DEPTH  = 8;
  localparam int ON     = 4;
  localparam int OFF    = 2;
  localparam int PERIOD = 2 + ON + OFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_player_if #(.DEPTH(DEPTH), .DATA_W(3)) bus ();

  seq_player #(
    .DEPTH(DEPTH), .DATA_W(3), .ON_CYCLES(ON), .OFF_CYCLES(OFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [2:0] mem [DEPTH];
  always_ff @(posedge clk) bus.rd_data_i <= mem[bus.rd_addr_o];

  logic [7:0] enc_tab [8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};

  typedef struct {
    logic [7:0] seg;
    logic       busy;
    logic       done;
    bit         addr_chk;
    int         addr;
  } cyc_t;

  typedef struct {
    int len;
    int pat;
    int exp_shown;
    int exp_busy;
  } vec_t;

  cyc_t exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, k, act, exp);
    end
  endtask

  function automatic void push(input logic [7:0] seg, input logic busy, input logic done,
                               input bit ac, input int addr);
    cyc_t c;
    c.seg = seg; c.busy = busy; c.done = done; c.addr_chk = ac; c.addr = addr;
    exp_q.push_back(c);
  endfunction

  // Expected cycle-by-cycle trace, starting with the first cycle after the start edge.
  function automatic void build(input int len, input int kill_at, input int kill_kind);
    int n = (len > DEPTH) ? DEPTH : len;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      push(8'h00, 1'b1, 1'b0, 1'b1, i);
      push(8'h00, 1'b1, 1'b0, 1'b0, 0);
      for (int j = 0; j < ON; j++)
        push(enc_tab[mem[i]] | ((i == n - 1) ? 8'h80 : 8'h00), 1'b1, 1'b0, 1'b0, 0);
      for (int j = 0; j < OFF; j++) push(8'h00, 1'b1, 1'b0, 1'b0, 0);
    end
    push(8'h00, 1'b1, 1'b1, 1'b0, 0);
    if (kill_kind != 0 && kill_at >= 0 && kill_at < exp_q.size()) begin
      while (exp_q.size() > kill_at + 1) void'(exp_q.pop_back());
    end
    push(8'h00, 1'b0, 1'b0, (kill_kind == 2), 0);
    push(8'h00, 1'b0, 1'b0, 1'b0, 0);
  endfunction

  // kill_kind: 0 none, 1 abort_i, 2 rst, asserted for one cycle at cycle kill_at.
  task automatic play(input int len, input int start_at, input int kill_at,
                      input int kill_kind, output int busy_cnt, output int shown_cnt);
    build(len, kill_at, kill_kind);
    busy_cnt = 0;
    shown_cnt = 0;
    @(negedge clk);
    bus.len_i   = 4'(len);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      chk("cycle_seg_busy_done", k, {22'd0, bus.seg_o, bus.busy_o, bus.done_o},
          {22'd0, exp_q[k].seg, exp_q[k].busy, exp_q[k].done});
      if (exp_q[k].addr_chk) chk("rd_addr", k, 32'(bus.rd_addr_o), 32'(exp_q[k].addr));
      if (int'(bus.rd_addr_o) >= DEPTH) chk("rd_addr_range", k, 32'(bus.rd_addr_o), 32'(DEPTH - 1));
      busy_cnt  += int'(bus.busy_o);
      shown_cnt += int'(bus.seg_o != 8'h00);
      bus.start_i = (k == start_at);
      bus.abort_i = (kill_kind == 1 && k == kill_at);
      rst         = (kill_kind == 2 && k == kill_at);
      @(negedge clk);
    end
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic load_pat(input int pat);
    for (int i = 0; i < DEPTH; i++) begin
      case (pat)
        0:       mem[i] = (i == 0) ? 3'd5 : (i == 1) ? 3'd2 : (i == 2) ? 3'd7 : 3'd0;
        1:       mem[i] = 3'(i);
        default: mem[i] = 3'(7 - i);
      endcase
    end
  endtask

  vec_t vecs [5];
  int b, s;

  initial begin
    vecs[0] = '{len: 3,  pat: 0, exp_shown: 3 * ON, exp_busy: 3 * PERIOD + 1};
    vecs[1] = '{len: 0,  pat: 0, exp_shown: 0,      exp_busy: 1};
    vecs[2] = '{len: 12, pat: 1, exp_shown: 8 * ON, exp_busy: 8 * PERIOD + 1};
    vecs[3] = '{len: 8,  pat: 2, exp_shown: 8 * ON, exp_busy: 8 * PERIOD + 1};
    vecs[4] = '{len: 1,  pat: 1, exp_shown: ON,     exp_busy: PERIOD + 1};

    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.len_i   = '0;
    load_pat(0);
    repeat (2) @(negedge clk);
    chk("reset_outputs", 0, {21'd0, bus.seg_o, bus.busy_o, bus.done_o, bus.rd_addr_o}, 32'd0);
    rst = 1'b0;

    foreach (vecs[v]) begin
      load_pat(vecs[v].pat);
      play(vecs[v].len, -1, -1, 0, b, s);
      chk("busy_cycles", v, 32'(b), 32'(vecs[v].exp_busy));
      chk("shown_cycles", v, 32'(s), 32'(vecs[v].exp_shown));
    end

    // Restart during SHOW of entry 1 is ignored; abort in its GAP ends without done.
    load_pat(0);
    play(3, PERIOD + 3, PERIOD + 2 + ON, 1, b, s);
    chk("abort_shown_cycles", 0, 32'(s), 32'(2 * ON));

    // start and abort together in IDLE: nothing happens.
    @(negedge clk);
    bus.len_i   = 4'd3;
    bus.start_i = 1'b1;
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("start_abort_idle", k, {22'd0, bus.seg_o, bus.busy_o, bus.done_o}, 32'd0);
      @(negedge clk);
    end

    // Reset mid-SHOW, then a fresh start replays from entry 0.
    play(3, -1, 3, 2, b, s);
    play(3, -1, -1, 0, b, s);
    chk("replay_busy_cycles", 0, 32'(b), 32'(3 * PERIOD + 1));

    for (int r = 0; r < 20; r++) begin
      int len, n, full, sa, ka, kk;
      for (int i = 0; i < DEPTH; i++) mem[i] = 3'($urandom_range(7));
      len  = $urandom_range(15);
      n    = (len > DEPTH) ? DEPTH : len;
      full = n * PERIOD + 3;
      sa = -1; ka = -1; kk = 0;
      case ($urandom_range(3))
        0: sa = $urandom_range(full - 3);
        1: begin ka = $urandom_range(full - 3); kk = 1; end
        2: begin ka = $urandom_range(full - 3); kk = 2; end
        default: ;
      endcase
      play(len, sa, ka, kk, b, s);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
